// File: rtl/uart_rx_char.sv
// 8N1 UART receiver: double-synchronised line, centre-sampled bits, one-cycle
// CharValid / FrameErr strobes and a Busy flag while a frame is in progress.
module uart_rx_char #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic [7:0] Char,
  output logic       CharValid,
  output logic       FrameErr,
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    WAITHI = 3'd4
  } state_e;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  char_q, char_d;
  logic        char_valid_q, char_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;
  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    char_d       = char_q;
    char_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    sync1_d      = Rx;
    rx_s_d       = sync1_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // A start bit that is already gone at its centre was a glitch.
        if (cnt_q == HALF_M1) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            char_d       = shreg_q;
            char_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAITHI;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAITHI: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
    end
  end

  assign Char      = char_q;
  assign CharValid = char_valid_q;
  assign FrameErr  = frame_err_q;
  assign Busy      = busy_q;

endmodule
